// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and default sizing.
package spi_master_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_HALF_DIV = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_master_clk_div.sv
// Half-period timer for the SPI master. While enabled it emits a one-cycle
// tick every HALF_DIV clocks; the count wraps to zero on each tick, which is
// exactly when the master changes state, and is held at zero when disabled.
module spi_master_clk_div #(
    parameter int HALF_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = $clog2(HALF_DIV + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_atLast;

    assign w_atLast = (r_count == LAST_COUNT);
    assign o_tick   = i_enable && w_atLast;

    // Count cycles within the current half-period; restart on tick or when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (!i_enable || w_atLast) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master: SLK idles low, the slave samples MOSI on SLK rise,
// MISO is captured on SLK fall, CS is active high. One frame per accepted start.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SLK,
    output logic              MOSI,
    output logic              CS,
    input  logic              MISO
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] ALL_BITS  = BIT_W'(DATA_W);

    spi_state_t        r_state;
    logic [DATA_W-2:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [BIT_W-1:0]  r_bitCnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rxData;
    logic              r_slk;
    logic              r_mosi;
    logic              r_cs;
    logic              w_tick;
    logic              w_divEnable;

    assign w_divEnable = (r_state != IDLE);

    spi_master_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clkDiv (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_enable (w_divEnable),
        .o_tick   (w_tick)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rxData;
    assign SLK     = r_slk;
    assign MOSI    = r_mosi;
    assign CS      = r_cs;

    // Frame sequencer: the MSB goes out on acceptance, the rest of the word is
    // held in r_tx and only advances on SLK fall so MOSI is stable across rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_tx     <= '0;
            r_rx     <= '0;
            r_bitCnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rxData <= '0;
            r_slk    <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx     <= tx_data[DATA_W-2:0];
                        r_mosi   <= tx_data[DATA_W-1];
                        r_rx     <= '0;
                        r_bitCnt <= '0;
                        r_cs     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_slk   <= 1'b1;
                        r_state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (w_tick) begin
                        r_slk    <= 1'b0;
                        r_rx     <= {r_rx[DATA_W-2:0], MISO};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt != LAST_BIT) begin
                            r_mosi <= r_tx[DATA_W-2];
                            r_tx   <= r_tx << 1;
                        end
                        r_state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (w_tick) begin
                        if (r_bitCnt == ALL_BITS) begin
                            r_state <= HOLD;
                        end else begin
                            r_slk   <= 1'b1;
                            r_state <= SHIFT_HI;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cs     <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_rxData <= r_rx;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a main instance with HALF_DIV=4 (loopback
// or a behavioural mode-0 slave on MISO) and a second instance with HALF_DIV=1.
module tb_spi_master;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;

    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       busy, done, SLK, MOSI, CS, MISO;
    logic [7:0] rxData;

    logic       startB = 1'b0;
    logic [7:0] txDataB = 8'h00;
    logic       busyB, doneB, slkB, mosiB, csB;
    logic [7:0] rxDataB;

    logic       useSlave = 1'b0;
    logic [7:0] slvReg = 8'h00;
    logic       slvCap = 1'b0;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] expQ[$];
    logic [7:0] expQB[$];
    logic       mosiSeen[$];
    logic       mosiSeenB[$];

    spi_master #(.DATA_W(8), .HALF_DIV(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .tx_data (txData),
        .busy    (busy),
        .done    (done),
        .rx_data (rxData),
        .SLK     (SLK),
        .MOSI    (MOSI),
        .CS      (CS),
        .MISO    (MISO)
    );

    spi_master #(.DATA_W(8), .HALF_DIV(1)) dutFast (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (startB),
        .tx_data (txDataB),
        .busy    (busyB),
        .done    (doneB),
        .rx_data (rxDataB),
        .SLK     (slkB),
        .MOSI    (mosiB),
        .CS      (csB),
        .MISO    (mosiB)
    );

    assign MISO = useSlave ? slvReg[7] : MOSI;

    // System clock and a free-running edge counter for latency measurement.
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record MOSI at every SLK rise, i.e. what the slave actually samples.
    always @(posedge SLK) mosiSeen.push_back(MOSI);

    always @(posedge slkB) mosiSeenB.push_back(mosiB);

    // Behavioural mode-0 slave: capture on rise, shift out on fall.
    always @(posedge SLK) if (useSlave && CS) slvCap = MOSI;

    always @(negedge SLK) if (useSlave && CS) slvReg = {slvReg[6:0], slvCap};

    // Scoreboard: every done pulse must match the oldest expected word.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got done with rx_data %h, expected no frame", rxData);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rxData !== e) begin
                    errors++;
                    $display("[TB] FAIL rx_data: got %h, expected %h", rxData, e);
                end
            end
        end
        if (doneB === 1'b1) begin
            checks++;
            if (expQB.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done_fast: got done with rx_data %h, expected no frame", rxDataB);
            end else begin
                logic [7:0] e;
                e = expQB.pop_front();
                if (rxDataB !== e) begin
                    errors++;
                    $display("[TB] FAIL rx_data_fast: got %h, expected %h", rxDataB, e);
                end
            end
        end
    end

    // One complete frame on the main instance with latency and MOSI-at-rise checks.
    task automatic runFrame(input logic [7:0] tx, input logic [7:0] expRx, input string name);
        int acc;
        int lat;
        expQ.push_back(expRx);
        mosiSeen.delete();
        @(negedge CLK);
        start = 1'b1;
        txData = tx;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                lat = cyc - acc;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (lat !== 72) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d edges, expected 72", name, lat);
        end
        checks++;
        if (mosiSeen.size() !== 8) begin
            errors++;
            $display("[TB] FAIL %s_slk_rises: got %0d, expected 8", name, mosiSeen.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (mosiSeen[b] !== tx[7-b]) begin
                    errors++;
                    $display("[TB] FAIL %s_mosi_bit%0d: got %b, expected %b", name, b, mosiSeen[b], tx[7-b]);
                end
            end
        end
        checks++;
        if ({CS, busy, SLK} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL %s_end_state: got CS/busy/SLK %b, expected 000", name, {CS, busy, SLK});
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        start = 1'b1;
        txData = 8'hFF;
        startB = 1'b1;
        txDataB = 8'hFF;
        repeat (3) @(negedge CLK);
        checks++;
        if ({SLK, MOSI, CS, busy, done, rxData} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero", {SLK, MOSI, CS, busy, done, rxData});
        end
        checks++;
        if ({slkB, mosiB, csB, busyB, doneB, rxDataB} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_fast: got %b, expected all zero", {slkB, mosiB, csB, busyB, doneB, rxDataB});
        end
        start = 1'b0;
        startB = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if ({CS, busy, SLK, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got CS/busy/SLK/done %b, expected 0000", {CS, busy, SLK, done});
        end
    endtask

    task automatic test_loopback();
        useSlave = 1'b0;
        runFrame(8'hA5, 8'hA5, "loopback_a5");
        repeat (5) @(negedge CLK);
        checks++;
        if (MOSI !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mosi_holds_lsb: got %b, expected 1", MOSI);
        end
        runFrame(8'h4E, 8'h4E, "loopback_4e");
        repeat (3) @(negedge CLK);
        checks++;
        if (MOSI !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mosi_holds_lsb2: got %b, expected 0", MOSI);
        end
    endtask

    task automatic test_slave();
        useSlave = 1'b1;
        slvReg = 8'h96;
        runFrame(8'h3C, 8'h96, "slave_3c");
        checks++;
        if (slvReg !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL slave_after_3c: got %h, expected 3c", slvReg);
        end
        runFrame(8'hFF, 8'h3C, "slave_ff");
        checks++;
        if (slvReg !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL slave_after_ff: got %h, expected ff", slvReg);
        end
        useSlave = 1'b0;
    endtask

    task automatic test_back_to_back();
        int prevDone;
        bit found;
        useSlave = 1'b0;
        repeat (3) expQ.push_back(8'hC3);
        @(negedge CLK);
        start = 1'b1;
        txData = 8'hC3;
        prevDone = -1;
        for (int f = 0; f < 3; f++) begin
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge CLK);
                if (done === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("[TB] FAIL b2b_done%0d: got no done within 200 cycles, expected one", f);
            end
            if (f > 0) begin
                checks++;
                if (cyc - prevDone !== 73) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d cycles, expected 73", f, cyc - prevDone);
                end
            end
            prevDone = cyc;
            checks++;
            if ({CS, busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL b2b_gap%0d: got CS/busy %b, expected 00", f, {CS, busy});
            end
            @(negedge CLK);
            checks++;
            if (f < 2) begin
                if ({CS, busy} !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL b2b_restart%0d: got CS/busy %b, expected 11", f, {CS, busy});
                end
                if (f == 1) start = 1'b0;
            end else begin
                if ({CS, busy} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL b2b_stop: got CS/busy %b, expected 00", {CS, busy});
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_ignore_midframe();
        int acc;
        int lat;
        int busyCount;
        useSlave = 1'b0;
        expQ.push_back(8'h96);
        mosiSeen.delete();
        @(negedge CLK);
        start = 1'b1;
        txData = 8'h96;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (i == 20 || i == 45) begin
                start = 1'b1;
                txData = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = cyc - acc;
                break;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        checks++;
        if (lat !== 72) begin
            errors++;
            $display("[TB] FAIL ignore_latency: got %0d edges, expected 72", lat);
        end
        checks++;
        if (mosiSeen.size() !== 8) begin
            errors++;
            $display("[TB] FAIL ignore_slk_rises: got %0d, expected 8", mosiSeen.size());
        end else begin
            logic [7:0] word;
            for (int b = 0; b < 8; b++) word[7-b] = mosiSeen[b];
            checks++;
            if (word !== 8'h96) begin
                errors++;
                $display("[TB] FAIL ignore_mosi_word: got %h, expected 96", word);
            end
        end
        busyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy === 1'b1) busyCount++;
        end
        checks++;
        if (busyCount !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_no_queue: got %0d busy cycles, expected 0", busyCount);
        end
    endtask

    task automatic test_reset_midframe();
        bit seen3;
        int doneCount;
        useSlave = 1'b0;
        mosiSeen.delete();
        @(negedge CLK);
        start = 1'b1;
        txData = 8'hF0;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        seen3 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            if (mosiSeen.size() >= 3) begin
                seen3 = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen3) begin
            errors++;
            $display("[TB] FAIL abort_third_rise: got %0d rises, expected 3", mosiSeen.size());
        end
        checks++;
        if ({CS, SLK, busy} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL abort_pre_state: got CS/SLK/busy %b, expected 111", {CS, SLK, busy});
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({CS, SLK, busy, done, MOSI, rxData} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b, expected all zero", {CS, SLK, busy, done, MOSI, rxData});
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (done === 1'b1) doneCount++;
        end
        checks++;
        if (doneCount !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done pulses, expected 0", doneCount);
        end
        runFrame(8'hE7, 8'hE7, "after_abort");
    endtask

    task automatic test_halfdiv1();
        int acc;
        int lat;
        expQB.push_back(8'hA5);
        mosiSeenB.delete();
        @(negedge CLK);
        startB = 1'b1;
        txDataB = 8'hA5;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        startB = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (doneB === 1'b1) begin
                lat = cyc - acc;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("[TB] FAIL fast_latency: got %0d edges, expected 18", lat);
        end
        checks++;
        if (mosiSeenB.size() !== 8) begin
            errors++;
            $display("[TB] FAIL fast_slk_rises: got %0d, expected 8", mosiSeenB.size());
        end else begin
            logic [7:0] word;
            for (int b = 0; b < 8; b++) word[7-b] = mosiSeenB[b];
            checks++;
            if (word !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL fast_mosi_word: got %h, expected a5", word);
            end
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_halfdiv1();
        repeat (5) @(negedge CLK);
        checks++;
        if (expQ.size() + expQB.size() !== 0) begin
            errors++;
            $display("[TB] FAIL pending_frames: got %0d outstanding, expected 0", expQ.size() + expQB.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
